// File: rtl/if_id_queue_pkg.sv
// Shared types and encodings for the IF/ID decoupling queue.
// Holds the queue entry layout, the all-zero bubble entry and the control-level encodings.
package if_id_queue_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int INST_W_DEF = 32;

  typedef struct packed {
    logic [ADDR_W_DEF-1:0] pc;
    logic [INST_W_DEF-1:0] inst;
    logic                  taken;
    logic [ADDR_W_DEF-1:0] pc_pred;
  } entry_t;

  // inst == 0 decodes as a bubble in ID
  localparam entry_t ENTRY_ZERO = '0;

  localparam logic JUMP   = 1'b1;
  localparam logic STALL  = 1'b1;
  localparam logic ENABLE = 1'b1;

endpackage

// File: rtl/if_id_fifo.sv
// DEPTH-entry circular buffer of fetch entries with push/pop/flush, occupancy and full.
// Push is refused while full, even if a pop happens in the same cycle.
module if_id_fifo
  import if_id_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  entry_t           din,
  output entry_t           head,
  output logic [CNT_W-1:0] count,
  output logic             full
);

  localparam int PTR_W = $clog2(DEPTH);

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign push_ok = en && !flush && push && !full;
  assign pop_ok  = en && !flush && pop && (count != '0);
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (en) begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push_ok) wr_ptr <= wr_ptr + 1'b1;
        if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        case ({push_ok, pop_ok})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/if_id_queue.sv
// IF/ID decoupling stage: FIFO plus registered output with flush, stall hold and empty-queue bypass.
// full_out is back-pressure to IF, derived from the registered occupancy with no look-ahead.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int INST_W = INST_W_DEF,
  parameter int DEPTH  = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  input  logic              pcJump_in,
  input  logic              stall_in,
  input  logic              instE_in,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [INST_W-1:0] inst_in,
  input  logic              taken_in,
  input  logic [ADDR_W-1:0] pcPred_in,
  output logic              full_out,
  output logic [CNT_W-1:0]  count_out,
  output logic              valid_out,
  output logic [ADDR_W-1:0] pc_out,
  output logic [INST_W-1:0] inst_out,
  output logic              taken_out,
  output logic [ADDR_W-1:0] pcPred_out
);

  entry_t           in_e;
  entry_t           head_e;
  entry_t           out_p0;
  logic             vld_p0;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             has_data;
  logic             fifo_push;
  logic             fifo_pop;

  assign in_e = '{pc: pc_in, inst: inst_in, taken: taken_in, pc_pred: pcPred_in};
  assign has_data = (cnt != '0);

  // An empty, unstalled queue bypasses the input straight to the output stage
  assign fifo_push = instE_in && ((stall_in == STALL) || has_data);
  assign fifo_pop  = (stall_in != STALL);

  if_id_fifo #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk_in),
    .rst   (rst_in),
    .en    (rdy_in == ENABLE),
    .flush (pcJump_in == JUMP),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (in_e),
    .head  (head_e),
    .count (cnt),
    .full  (full)
  );

  // Output stage p0
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      out_p0 <= ENTRY_ZERO;
      vld_p0 <= 1'b0;
    end else if (rdy_in == ENABLE) begin
      if (pcJump_in == JUMP) begin
        out_p0 <= ENTRY_ZERO;
        vld_p0 <= 1'b0;
      end else if (stall_in != STALL) begin
        if (has_data) begin
          out_p0 <= head_e;
          vld_p0 <= 1'b1;
        end else if (instE_in) begin
          out_p0 <= in_e;
          vld_p0 <= 1'b1;
        end else begin
          out_p0 <= ENTRY_ZERO;
          vld_p0 <= 1'b0;
        end
      end
    end
  end

  assign full_out   = full;
  assign count_out  = cnt;
  assign valid_out  = vld_p0;
  assign pc_out     = out_p0.pc;
  assign inst_out   = out_p0.inst;
  assign taken_out  = out_p0.taken;
  assign pcPred_out = out_p0.pc_pred;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: reset, straight flow, stall fill, flush, rdy freeze, wrap-around.
module tb_if_id_queue;
  import if_id_queue_pkg::*;

  localparam int DEPTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             rdy;
  logic             jump;
  logic             stall;
  logic             inst_e;
  logic [31:0]      pc_in;
  logic [31:0]      inst_in;
  logic             taken_in;
  logic [31:0]      pc_pred_in;
  logic             full;
  logic [CNT_W-1:0] count;
  logic             valid;
  logic [31:0]      pc_out;
  logic [31:0]      inst_out;
  logic             taken_out;
  logic [31:0]      pc_pred_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mq[$];
  logic        mvld;
  logic [31:0] mpc;
  logic [31:0] pcn;
  logic        ie;
  logic [31:0] st_pat;
  logic [31:0] ie_pat;

  if_id_queue #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) dut (
    .clk_in     (clk),
    .rst_in     (rst),
    .rdy_in     (rdy),
    .pcJump_in  (jump),
    .stall_in   (stall),
    .instE_in   (inst_e),
    .pc_in      (pc_in),
    .inst_in    (inst_in),
    .taken_in   (taken_in),
    .pcPred_in  (pc_pred_in),
    .full_out   (full),
    .count_out  (count),
    .valid_out  (valid),
    .pc_out     (pc_out),
    .inst_out   (inst_out),
    .taken_out  (taken_out),
    .pcPred_out (pc_pred_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic e, input logic [31:0] pc);
    inst_e     = e;
    pc_in      = pc;
    inst_in    = pc ^ 32'hA5A5_0000;
    taken_in   = pc[2];
    pc_pred_in = pc + 32'd8;
  endtask

  // Output fields are all derived from pc as in drive(); a bubble is all zero
  task automatic chk_out(input string tag, input logic v, input logic [31:0] pc, input int c);
    chk({tag, ".vld"},   64'(valid),       64'(v));
    chk({tag, ".pc"},    64'(pc_out),      64'(v ? pc : 32'd0));
    chk({tag, ".inst"},  64'(inst_out),    64'(v ? (pc ^ 32'hA5A5_0000) : 32'd0));
    chk({tag, ".taken"}, 64'(taken_out),   64'(v ? pc[2] : 1'b0));
    chk({tag, ".pred"},  64'(pc_pred_out), 64'(v ? (pc + 32'd8) : 32'd0));
    chk({tag, ".cnt"},   64'(count),       64'(c));
    chk({tag, ".full"},  64'(full),        64'(c == DEPTH));
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; rdy = 1'b1; jump = 1'b0; stall = 1'b0;
    drive(1'b0, 32'd0);
    #2;
    chk_out("reset", 1'b0, 32'd0, 0);
    #10 rst = 1'b0;
    step();

    stall = 1'b1;
    drive(1'b1, 32'h10); step();
    drive(1'b1, 32'h14); step();
    drive(1'b1, 32'h18); step();
    drive(1'b0, 32'd0);
    chk("pre_rst.cnt", 64'(count), 64'd3);
    #2 rst = 1'b1;
    #1 chk_out("async_rst", 1'b0, 32'd0, 0);
    #1 rst = 1'b0;
    stall = 1'b0;

    drive(1'b1, 32'h0); step(); chk_out("flow0", 1'b1, 32'h0, 0);
    drive(1'b1, 32'h4); step(); chk_out("flow1", 1'b1, 32'h4, 0);
    drive(1'b1, 32'h8); step(); chk_out("flow2", 1'b1, 32'h8, 0);
    drive(1'b0, 32'h0); step(); chk_out("flow_bub", 1'b0, 32'h0, 0);

    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h40 + 32'(4 * i));
      step();
    end
    chk_out("fill", 1'b0, 32'h0, 4);
    stall = 1'b0;
    drive(1'b0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk_out("drain", 1'b1, 32'h40 + 32'(4 * i), 3 - i);
    end
    step(); chk_out("drain_bub", 1'b0, 32'h0, 0);

    stall = 1'b1;
    drive(1'b1, 32'h80); step();
    drive(1'b1, 32'h84); step();
    chk("pre_flush.cnt", 64'(count), 64'd2);
    jump = 1'b1;
    drive(1'b1, 32'h99); step();
    jump = 1'b0; stall = 1'b0;
    drive(1'b0, 32'h0);
    chk_out("flush", 1'b0, 32'h0, 0);
    step(); chk_out("post_flush", 1'b0, 32'h0, 0);

    drive(1'b1, 32'h100); step(); chk_out("rdy_pre", 1'b1, 32'h100, 0);
    stall = 1'b1;
    drive(1'b1, 32'h104); step();
    drive(1'b1, 32'h108); step();
    chk_out("rdy_fill", 1'b1, 32'h100, 2);
    rdy = 1'b0; stall = 1'b0;
    for (int i = 0; i < 3; i++) begin
      jump = (i != 1);
      drive(i[0], 32'h200);
      step();
      chk_out("rdy_low", 1'b1, 32'h100, 2);
    end
    rdy = 1'b1; jump = 1'b0;
    drive(1'b0, 32'h0);
    step(); chk_out("rdy_rel0", 1'b1, 32'h104, 1);
    step(); chk_out("rdy_rel1", 1'b1, 32'h108, 0);
    step(); chk_out("rdy_rel2", 1'b0, 32'h0, 0);

    mq.delete();
    mvld = 1'b0; mpc = 32'd0; pcn = 32'h300;
    st_pat = 32'b0000_0000_0011_0110_1110_0111_0011_1100;
    ie_pat = 32'b0000_0000_1110_1111_0111_1101_1111_0011;
    for (int i = 0; i < 32; i++) begin
      ie = ie_pat[i] && (mq.size() < DEPTH);
      stall = st_pat[i];
      drive(ie, pcn);
      if (stall) begin
        if (ie) mq.push_back(pcn);
      end else if (mq.size() > 0) begin
        mpc = mq.pop_front();
        mvld = 1'b1;
        if (ie) mq.push_back(pcn);
      end else if (ie) begin
        mpc = pcn;
        mvld = 1'b1;
      end else begin
        mpc = 32'd0;
        mvld = 1'b0;
      end
      if (ie) pcn = pcn + 32'd4;
      step();
      chk_out("wrap", mvld, mpc, mq.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
